// File: rtl/reaction_timer_if.sv
// Handshake bundle between the start-lights sequencer, player button and the reaction timer.
// The master drives the control inputs and the slave (the timer) returns the BCD results and status flags.
interface reaction_timer_if #(
    parameter int DIGITS = 4
);
    logic                  tick_ms;
    logic                  arm;
    logic                  go;
    logic                  btn;
    logic                  clear;
    logic [4*DIGITS-1:0]   result_bcd;
    logic [4*DIGITS-1:0]   best_bcd;
    logic                  timing;
    logic                  valid;
    logic                  false_start;
    logic                  overflow;

    modport master (
        output tick_ms, arm, go, btn, clear,
        input  result_bcd, best_bcd, timing, valid, false_start, overflow
    );

    modport slave (
        input  tick_ms, arm, go, btn, clear,
        output result_bcd, best_bcd, timing, valid, false_start, overflow
    );
endinterface

// File: rtl/reaction_timer.sv
// Reaction timer: arms with the start lights, counts BCD milliseconds from lights-out to the button press,
// flags false starts and keeps the best valid time.
module reaction_timer #(
    parameter int                  DIGITS    = 4,
    parameter logic [4*DIGITS-1:0] BEST_INIT = 16'h9999
) (
    input  logic             clk,
    input  logic             rst_n,
    reaction_timer_if.slave  bus
);
    localparam int            W     = 4 * DIGITS;
    localparam logic [W-1:0]  NINES = {DIGITS{4'h9}};

    typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FAULT} state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_btn_d;
    logic           r_arm_d;
    logic           r_ovf;
    logic           r_done_entry;
    logic [W-1:0]   r_result;
    logic [W-1:0]   r_best;
    logic [W-1:0]   w_result_next;
    logic           w_ovf_next;
    logic           w_press;
    logic           w_arm_rise;
    logic           w_arm_fall;
    logic           w_all_nines;
    logic           w_valid;

    // Ripple BCD increment; each digit at 9 wraps to 0 and passes the carry on.
    function automatic logic [W-1:0] bcdInc(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic         carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign w_press     = bus.btn & ~r_btn_d;
    assign w_arm_rise  = bus.arm & ~r_arm_d;
    assign w_arm_fall  = ~bus.arm & r_arm_d;
    assign w_all_nines = (r_result == NINES);
    assign w_valid     = (r_state == DONE) & ~r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.clear) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_arm_rise) w_next = ARMED;
                ARMED: begin
                    if (w_press)         w_next = FAULT;
                    else if (bus.go)     w_next = TIMING;
                    else if (w_arm_fall) w_next = IDLE;
                end
                TIMING: begin
                    if (w_press)                        w_next = DONE;
                    else if (bus.tick_ms && w_all_nines) w_next = DONE;
                end
                DONE:    if (w_arm_rise) w_next = ARMED;
                FAULT:   if (w_arm_rise) w_next = ARMED;
                default: w_next = IDLE;
            endcase
        end
    end

    // A press in the same cycle as a tick freezes the count without adding that tick.
    always_comb begin
        w_result_next = r_result;
        w_ovf_next    = r_ovf;
        if (bus.clear) begin
            w_result_next = '0;
            w_ovf_next    = 1'b0;
        end else begin
            case (r_state)
                IDLE:  if (w_arm_rise) w_result_next = '0;
                ARMED: if (w_press || bus.go) w_result_next = '0;
                TIMING: begin
                    if (!w_press && bus.tick_ms) begin
                        if (w_all_nines) w_ovf_next = 1'b1;
                        else             w_result_next = bcdInc(r_result);
                    end
                end
                DONE, FAULT: begin
                    if (w_arm_rise) begin
                        w_result_next = '0;
                        w_ovf_next    = 1'b0;
                    end
                end
                default: begin
                    w_result_next = '0;
                    w_ovf_next    = 1'b0;
                end
            endcase
        end
    end

    // Packed BCD orders the same as binary, so a plain unsigned compare picks the lower time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_d      <= 1'b0;
            r_arm_d      <= 1'b0;
            r_result     <= '0;
            r_ovf        <= 1'b0;
            r_done_entry <= 1'b0;
            r_best       <= BEST_INIT;
        end else begin
            r_btn_d      <= bus.btn;
            r_arm_d      <= bus.arm;
            r_result     <= w_result_next;
            r_ovf        <= w_ovf_next;
            r_done_entry <= (r_state != DONE) && (w_next == DONE);
            if (r_done_entry && w_valid && !bus.clear && (r_result < r_best)) begin
                r_best <= r_result;
            end
        end
    end

    assign bus.result_bcd  = r_result;
    assign bus.best_bcd    = r_best;
    assign bus.timing      = (r_state == TIMING);
    assign bus.valid       = w_valid;
    assign bus.false_start = (r_state == FAULT);
    assign bus.overflow    = (r_state == DONE) & r_ovf;
endmodule

// File: tb/tb_reaction_timer.sv
// Directed self-checking bench for reaction_timer.
// Steps are written linearly; every expected value is hand computed.
module tb_reaction_timer;
    logic clk;
    logic rst_n;
    int   nChecks = 0;
    int   nPass   = 0;
    logic [3:0] flags;

    reaction_timer_if #(.DIGITS(4)) bus ();

    reaction_timer #(.DIGITS(4), .BEST_INIT(16'h9999)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag order: timing, valid, false_start, overflow.
    assign flags = {bus.timing, bus.valid, bus.false_start, bus.overflow};

    task automatic applyStimulus(input logic a, input logic g, input logic b,
                                 input logic t, input logic c);
        bus.arm     = a;
        bus.go      = g;
        bus.btn     = b;
        bus.tick_ms = t;
        bus.clear   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic startRound();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("go_latency_flags", {12'h0, flags}, 16'h0008);
        checkOutput("go_latency_result", bus.result_bcd, 16'h0000);
    endtask

    task automatic ticks(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Invariants: at most one status flag, and no non-decimal digit in the result.
    always @(negedge clk) begin
        nChecks++;
        assert ($onehot0(flags) && bus.result_bcd[3:0] <= 4'd9 && bus.result_bcd[7:4] <= 4'd9
                && bus.result_bcd[11:8] <= 4'd9 && bus.result_bcd[15:12] <= 4'd9) nPass++;
        else $error("[TB] FAIL invariant flags=%b result=%h", flags, bus.result_bcd);
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_result", bus.result_bcd, 16'h0000);
        checkOutput("reset_best", bus.best_bcd, 16'h9999);
        checkOutput("reset_flags", {12'h0, flags}, 16'h0000);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        startRound();
        ticks(237);
        checkOutput("r1_counting", bus.result_bcd, 16'h0237);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("r1_result", bus.result_bcd, 16'h0237);
        checkOutput("r1_flags", {12'h0, flags}, 16'h0004);
        checkOutput("r1_best_before", bus.best_bcd, 16'h9999);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("r1_best", bus.best_bcd, 16'h0237);

        startRound();
        ticks(412);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("r2_result", bus.result_bcd, 16'h0412);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("r2_best", bus.best_bcd, 16'h0237);

        startRound();
        ticks(199);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("r3_result", bus.result_bcd, 16'h0199);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("r3_best", bus.best_bcd, 16'h0199);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("armed_flags", {12'h0, flags}, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("fs_flags", {12'h0, flags}, 16'h0002);
        checkOutput("fs_result", bus.result_bcd, 16'h0000);
        checkOutput("fs_best", bus.best_bcd, 16'h0199);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fs_hold", {12'h0, flags}, 16'h0002);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fs_rearm", {12'h0, flags}, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("fs_press_go", {12'h0, flags}, 16'h0002);

        startRound();
        ticks(9999);
        checkOutput("ovf_at_nines", bus.result_bcd, 16'h9999);
        checkOutput("ovf_still_timing", {12'h0, flags}, 16'h0008);
        ticks(1);
        checkOutput("ovf_result", bus.result_bcd, 16'h9999);
        checkOutput("ovf_flags", {12'h0, flags}, 16'h0001);
        ticks(1);
        checkOutput("ovf_best", bus.best_bcd, 16'h0199);
        checkOutput("ovf_hold", bus.result_bcd, 16'h9999);

        startRound();
        ticks(41);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("press_tick_result", bus.result_bcd, 16'h0041);
        checkOutput("press_tick_flags", {12'h0, flags}, 16'h0004);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("press_tick_best", bus.best_bcd, 16'h0041);

        startRound();
        ticks(99);
        checkOutput("carry_0099", bus.result_bcd, 16'h0099);
        ticks(1);
        checkOutput("carry_0100", bus.result_bcd, 16'h0100);
        ticks(899);
        checkOutput("carry_0999", bus.result_bcd, 16'h0999);
        ticks(1);
        checkOutput("carry_1000", bus.result_bcd, 16'h1000);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("carry_done", {12'h0, flags}, 16'h0004);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("carry_best", bus.best_bcd, 16'h0041);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("held_armed", {12'h0, flags}, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("held_go", {12'h0, flags}, 16'h0008);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("held_count", bus.result_bcd, 16'h0005);
        checkOutput("held_timing", {12'h0, flags}, 16'h0008);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("held_repress", bus.result_bcd, 16'h0005);
        checkOutput("held_valid", {12'h0, flags}, 16'h0004);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("held_best", bus.best_bcd, 16'h0005);

        startRound();
        ticks(123);
        checkOutput("rst_mid_count", bus.result_bcd, 16'h0123);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_result", bus.result_bcd, 16'h0000);
        checkOutput("rst_mid_best", bus.best_bcd, 16'h9999);
        checkOutput("rst_mid_flags", {12'h0, flags}, 16'h0000);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        startRound();
        ticks(50);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("clr_pre_result", bus.result_bcd, 16'h0050);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("clr_pre_best", bus.best_bcd, 16'h0050);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_result", bus.result_bcd, 16'h0000);
        checkOutput("clr_flags", {12'h0, flags}, 16'h0000);
        checkOutput("clr_best", bus.best_bcd, 16'h0050);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("clr_priority", {12'h0, flags}, 16'h0000);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
